ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: the send side of the keyboard link whose receive side is kbd_if.
//  Inhibits the bus, issues the request-to-send, and shifts one byte, odd parity and stop bit out
//  on device-generated clocks. It then checks the device ACK.
//  Used by the alarm clock top to send keyboard commands (0xED set-LEDs, 0xF4 enable, 0xFF reset).
//  Drives open-drain enables only; the top level builds PS2C/PS2D as (oe ? 1'b0 : 1'bz).
// PARAMETERS
//  INHIBIT_CYCLES  2500    clk cycles PS2C is held low before the request (100us @ 25MHz)
//  TIMEOUT_CYCLES  375000  max clk cycles between device falling edges, or before the first one (15ms)
//  CNT_W           19      width of the shared inhibit/timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk       in   1  system clock (MCLK domain)
//  reset     in   1  asynchronous, active-low reset
//  ps2c_in   in   1  raw PS2C pad value (asynchronous; synchronized here)
//  ps2d_in   in   1  raw PS2D pad value (asynchronous; synchronized here)
//  ps2c_oe   out  1  1 = pull PS2C low
//  ps2d_oe   out  1  1 = pull PS2D low
//  tx_data   in   8  byte to send; sampled on an accepted tx_start
//  tx_start  in   1  one-cycle request; accepted only when tx_busy=0
//  tx_busy   out  1  1 from the cycle after acceptance until done/err; kbd_if ignores frames while high
//  tx_done   out  1  one-cycle pulse: byte sent, ACK seen, bus idle
//  tx_err    out  1  one-cycle pulse: transfer aborted
//  err_code  out  2  valid with tx_err and held until the next accept: 01 timeout, 10 no ACK
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; ps2c_oe=0, ps2d_oe=0; tx_busy/done/err=0; err_code=00; counters cleared.
//   - Synchronizers reset to 1. Lines are released immediately, including mid-frame.
//  Sync and edge detect:
//   - Two-flop synchronizer on each input; fall = sync_c_prev & ~sync_c.
//   - A falling edge is acted on 3 clk after the pad edge.
//  FSM:
//   IDLE     tx_start & ~tx_busy -> latch shreg = {1'b1, ~^tx_data, tx_data} (stop, odd parity, data LSB first).
//            Set bitcnt=0 and cnt=0; go to INHIBIT.
//   INHIBIT  ps2c_oe=1. In cycle cnt==INHIBIT_CYCLES-1, also set ps2d_oe=1 (start bit).
//            Next cycle: ps2c_oe=0 and go to REQ.
//   REQ      ps2c_oe=0, ps2d_oe=1; wait for fall, then go to SHIFT.
//            The device samples the start bit on this clock, so this fall drives d0.
//   SHIFT    On each fall: ps2d_oe = ~shreg[0]; shift right; bitcnt++.
//            Falls 1..8 drive d0..d7, fall 9 drives parity, fall 10 drives stop (ps2d_oe=0).
//            After fall 10, go to ACK.
//   ACK      On the next fall (11th), sample sync_d: 0 -> go to WAIT_IDLE; 1 -> err, err_code=10.
//   WAIT_IDLE Wait for sync_c=1 and sync_d=1 for 1 cycle, then DONE.
//   DONE     tx_done=1 for one cycle; go to IDLE.
//  Timeout:
//   - In REQ, SHIFT, ACK and WAIT_IDLE, cnt increments each clk and clears on every fall.
//   - When cnt reaches TIMEOUT_CYCLES-1: release both lines, tx_err=1, err_code=01, go to IDLE.
//  Outputs, latency and counter rules:
//   - tx_busy=1 in all states except IDLE; it is 0 in the tx_done/tx_err pulse cycle.
//   - Accept-to-first-line-change latency: 1 clk (ps2c_oe rises the cycle after tx_start).
//   - tx_start while busy is dropped; tx_data changes while busy are ignored.
//   - A fall coincident with a timeout terminal count: the fall wins and clears cnt.
//   - Parity is always computed from the latched byte. Counters saturate and never wrap.
//   - Device-originated frames are not handled here; they belong to kbd_if.
// TESTING (bench: device model on open-drain lines with pullups; INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200)
//  1. tx_data=0xED, model clocks and ACKs.
//     -> model captures 0xED, parity=1, stop=1; tx_done once; err_code=00.
//  2. tx_data=0xF4 -> model captures parity=0.
//     -> ps2c_oe high exactly 8 clk; ps2d_oe rises on the 8th.
//  3. Model clocks all 11 edges but leaves PS2D high at edge 11.
//     -> tx_err, err_code=10, both oe=0.
//  4. Model never clocks after the request.
//     -> tx_err with err_code=01 exactly 200 clk after entering REQ; lines released.
//  5. reset=0 after fall 5, held 1 clk.
//     -> ps2c_oe=ps2d_oe=0 immediately, busy=0; a later 0xFF sends cleanly.
//  6. Second tx_start (0x00) while busy with 0xED.
//     -> ignored; only 0xED is seen by the model; exactly one tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift byte/parity/stop on
// device clock falls, then check the device ACK. Drives open-drain pull-low enables only.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int CNT_W          = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] INH_PRE  = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [1:0]       ERR_TO   = 2'b01;
    localparam logic [1:0]       ERR_NACK = 2'b10;

    state_t           r_state, w_state;
    logic             r_c_meta, r_c_sync, r_c_prev;
    logic             r_d_meta, r_d_sync;
    logic [9:0]       r_shreg, w_shreg;
    logic [3:0]       r_bitcnt, w_bitcnt;
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_c_oe, w_c_oe;
    logic             r_d_oe, w_d_oe;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             r_err, w_err;
    logic [1:0]       r_err_code, w_err_code;

    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [3:0]       w_bitcnt_inc;

    assign w_fall       = r_c_prev & ~r_c_sync;
    assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_bitcnt_inc = (r_bitcnt == 4'hF) ? r_bitcnt : r_bitcnt + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_meta   <= 1'b1;
            r_c_sync   <= 1'b1;
            r_c_prev   <= 1'b1;
            r_d_meta   <= 1'b1;
            r_d_sync   <= 1'b1;
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_cnt      <= '0;
            r_c_oe     <= 1'b0;
            r_d_oe     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_c_meta   <= ps2c_in;
            r_c_sync   <= r_c_meta;
            r_c_prev   <= r_c_sync;
            r_d_meta   <= ps2d_in;
            r_d_sync   <= r_d_meta;
            r_state    <= w_state;
            r_shreg    <= w_shreg;
            r_bitcnt   <= w_bitcnt;
            r_cnt      <= w_cnt;
            r_c_oe     <= w_c_oe;
            r_d_oe     <= w_d_oe;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
            r_err_code <= w_err_code;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_shreg    = r_shreg;
        w_bitcnt   = r_bitcnt;
        w_cnt      = r_cnt;
        w_c_oe     = r_c_oe;
        w_d_oe     = r_d_oe;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_err_code = r_err_code;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_c_oe = 1'b0;
                w_d_oe = 1'b0;
                if (r_state == S_DONE) w_state = S_IDLE;
                if (tx_start) begin
                    w_shreg    = {1'b1, ~^tx_data, tx_data};
                    w_bitcnt   = '0;
                    w_cnt      = '0;
                    w_c_oe     = 1'b1;
                    w_d_oe     = (INHIBIT_CYCLES == 1);
                    w_err_code = 2'b00;
                    w_state    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                // Outputs are registered, so the start bit is set one cycle ahead.
                if (r_cnt == INH_LAST) begin
                    w_cnt   = '0;
                    w_c_oe  = 1'b0;
                    w_d_oe  = 1'b1;
                    w_state = S_REQ;
                end else begin
                    w_cnt = w_cnt_inc;
                    if (r_cnt == INH_PRE) w_d_oe = 1'b1;
                end
            end
            S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                if (w_fall) begin
                    w_cnt = '0;
                    if (r_state == S_ACK) begin
                        if (!r_d_sync) begin
                            w_state = S_WAIT_IDLE;
                        end else begin
                            w_err      = 1'b1;
                            w_err_code = ERR_NACK;
                            w_state    = S_IDLE;
                        end
                    end else if (r_state != S_WAIT_IDLE) begin
                        // The REQ fall is the one that drives d0; fall 10 drives the stop bit.
                        w_d_oe   = ~r_shreg[0];
                        w_shreg  = {1'b0, r_shreg[9:1]};
                        w_bitcnt = w_bitcnt_inc;
                        w_state  = (w_bitcnt_inc >= 4'd10) ? S_ACK : S_SHIFT;
                    end
                end else if (r_state == S_WAIT_IDLE && r_c_sync && r_d_sync) begin
                    w_cnt   = '0;
                    w_done  = 1'b1;
                    w_state = S_DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_cnt      = '0;
                    w_c_oe     = 1'b0;
                    w_d_oe     = 1'b0;
                    w_err      = 1'b1;
                    w_err_code = ERR_TO;
                    w_state    = S_IDLE;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            default: begin
                w_c_oe  = 1'b0;
                w_d_oe  = 1'b0;
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE) && (w_state != S_DONE);
    end

    assign ps2c_oe  = r_c_oe;
    assign ps2d_oe  = r_d_oe;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;
    assign tx_err   = r_err;
    assign err_code = r_err_code;

endmodule
